spi_stream_engine: RTL
======================

Name: spi_stream_engine

Overview:
- Parametrised SPI-flash read streaming engine. Issues opcode, address, optional dummy cycles, then streams N data words into an internal RX FIFO drained by a valid/ready port.
- Adds configurable address width, word width, FIFO depth and dummy cycles (fast-read 0x0B), plus abort.
- Sits behind a CSR block or DMA. SPI mode 0, single-bit MOSI/MISO only, for use through unidirectional level shifters.

Parameters:
- W_ADDR, 24: flash byte-address width, sent MSB-first; must be a multiple of 8.
- W_DATA, 32: bits per FIFO word; must be a multiple of 8.
- W_COUNT, 16: width of the word counter.
- FIFO_DEPTH, 4: RX FIFO entries; must be a power of 2 and at least 2.
- W_CLKDIV, 4: width of the clock divider value.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle start pulse
- abort  in  1  one-cycle abort pulse
- opcode  in  8  read command byte
- dummy_cycles  in  4  SCK cycles inserted after the address (0 = none)
- clkdiv  in  W_CLKDIV  SCK half-period in clk cycles (0 is treated as 1)
- addr_i  in  W_ADDR  address write value
- addr_wen  in  1  address write strobe
- count_i  in  W_COUNT  count write value (words minus 1)
- count_wen  in  1  count write strobe
- addr_o  out  W_ADDR  live byte address
- count_o  out  W_COUNT  live remaining count
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse on normal completion
- pause_req  in  1  request to release the bus between words
- pause_ack  out  1  engine is paused
- flush  in  1  empty the FIFO
- rx_data  out  W_DATA  FIFO head
- rx_valid  out  1  FIFO not empty
- rx_ready  in  1  pop the FIFO when rx_valid is high
- rx_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- spi_cs_n  out  1  chip select
- spi_sck  out  1  serial clock
- spi_mosi  out  1  serial data out
- spi_miso  in  1  serial data in

Behaviour:
- Reset values: spi_cs_n=1; spi_sck=0; spi_mosi=0; addr=0; count=0; busy=0; done=0; pause_ack=0; FIFO empty.
- Divider: clk_en is asserted once every max(clkdiv,1) cycles. All FSM advances happen only on clk_en.
- start is latched sticky until the next clk_en. start while busy is ignored and the latch is cleared.
- States:
  - IDLE: start -> FRONTPORCH with cs_n=0; pause_req -> PAUSED_IDLE.
  - FRONTPORCH: load the opcode into the shifter, drive MOSI=opcode[7], go to CMD.
  - CMD (8 bits), then ADDR (W_ADDR bits), then DUMMY (dummy_cycles SCK cycles, MOSI=0, skipped if 0), then DATA.
  - In CMD/ADDR/DUMMY/DATA, SCK toggles on every clk_en. MOSI updates and the bit counter decrements when SCK falls.
  - DATA: MISO is sampled on the clk_en that launches the falling edge. After W_DATA bits the word is pushed:
    - FIFO full -> FIFO_WAIT (SCK held low).
    - Otherwise push; addr += W_DATA/8; count -= 1.
    - Then: count was 0 -> BACKPORCH; pause_req -> TO_PAUSE; else continue DATA.
  - FIFO_WAIT: same push and transition rules once the FIFO has space.
  - TO_PAUSE: cs_n=1 -> PAUSED_BUSY.
  - PAUSED_BUSY: on !pause_req -> FRONTPORCH, reissuing opcode and the current address.
  - PAUSED_IDLE: start -> PAUSED_BUSY; !pause_req -> IDLE.
  - BACKPORCH: cs_n=1, done pulses, -> IDLE.
- pause_ack is high in PAUSED_IDLE and PAUSED_BUSY.
- busy is high when state is neither IDLE nor PAUSED_IDLE.
- Address and count arithmetic wraps modulo 2^W.
- addr_wen and count_wen override the FSM update in the same cycle.
- abort (acts immediately, independent of clk_en): cs_n=1, sck=0, state -> IDLE or PAUSED_IDLE per pause_req. No done pulse. The partial word is discarded and FIFO contents are kept.
- flush empties the FIFO. A flush coinciding with a push discards the pushed word.
- rx_valid/rx_ready: a simultaneous pop and push when full is allowed and the level is unchanged.

Optional Feature:
- Macro SPI_STREAM_ENGINE_BSWAP_EN.
- Defined: each word is byte-reversed on push, so the first flash byte lands in rx_data[7:0] (little-endian).
- Undefined: the first received bit is the word MSB.

Decomposition:
- Package spi_stream_pkg holds the state enum (4 bits), the default opcodes (READ=8'h03, FAST_READ=8'h0B) and the W_STATE constant.
- One sub-module: the RX FIFO, reusing sync_fifo (DEPTH=FIFO_DEPTH, WIDTH=W_DATA) with the flush and level ports.

Test Plan:
- clkdiv=1, opcode=03, addr=0x001000, count=0, flash model returns DEADBEEF -> CS low for 8+24+32 SCK cycles; rx_data=DEADBEEF; addr_o=0x001004; one done pulse.
- opcode=0B, dummy_cycles=8, count=3 -> 8 idle SCK cycles before data; 4 words arrive in order; rx_level peaks at 4.
- FIFO_DEPTH=2, rx_ready=0, count=4 -> engine stalls in FIFO_WAIT with SCK low; with rx_ready=1 all 5 words are delivered and none lost.
- pause_req asserted mid-transfer at word 2 of count=5 -> CS high after word 2 and pause_ack=1; on release, opcode is reissued with addr=base+8.
- abort during ADDR -> CS high next cycle, busy=0, no done pulse; a subsequent start completes normally.
- clkdiv=3, BSWAP build -> SCK period is 6 clk cycles; bytes 11 22 33 44 yield rx_data=44332211.

Source files
------------

// File: rtl/spi_stream_pkg.sv
// Shared types and constants for the SPI-flash read streaming engine.
// State encoding plus the default read opcodes.
package spi_stream_pkg;

  localparam int W_STATE = 4;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  typedef enum logic [W_STATE-1:0] {
    S_IDLE,
    S_FRONTPORCH,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_FIFO_WAIT,
    S_TO_PAUSE,
    S_PAUSED_BUSY,
    S_PAUSED_IDLE,
    S_BACKPORCH
  } state_e;

endpackage

// File: rtl/spi_stream_engine_if.sv
// Receive-stream handshake bundle between the engine FIFO and its consumer.
// master = engine side, slave = consumer side.
interface spi_stream_engine_if #(
  parameter int W_DATA     = 32,
  parameter int FIFO_DEPTH = 4
);

  logic [W_DATA-1:0]           rx_data;
  logic                        rx_valid;
  logic                        rx_ready;
  logic [$clog2(FIFO_DEPTH):0] rx_level;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_level,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_level,
    output rx_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush and occupancy; push while full is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level    = wr_ptr - rd_ptr;
  assign full     = level == (AW+1)'(DEPTH);
  assign empty    = level == '0;
  assign do_pop   = pop & !empty;
  assign do_push  = push & (!full | do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/spi_stream_engine.sv
// SPI-flash read streamer (mode 0): opcode, address, dummy, N words to FIFO.
// SPI_STREAM_ENGINE_BSWAP_EN: store words byte-reversed (first byte in [7:0]).
module spi_stream_engine
  import spi_stream_pkg::*;
#(
  parameter int W_ADDR     = 24,
  parameter int W_DATA     = 32,
  parameter int W_COUNT    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int W_CLKDIV   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [7:0]          opcode,
  input  logic [3:0]          dummy_cycles,
  input  logic [W_CLKDIV-1:0] clkdiv,
  input  logic [W_ADDR-1:0]   addr_i,
  input  logic                addr_wen,
  input  logic [W_COUNT-1:0]  count_i,
  input  logic                count_wen,
  output logic [W_ADDR-1:0]   addr_o,
  output logic [W_COUNT-1:0]  count_o,
  output logic                busy,
  output logic                done,
  input  logic                pause_req,
  output logic                pause_ack,
  input  logic                flush,
  spi_stream_engine_if.master rx,
  output logic                spi_cs_n,
  output logic                spi_sck,
  output logic                spi_mosi,
  input  logic                spi_miso
);

  localparam int W_MAXB = (W_ADDR > W_DATA) ? W_ADDR : W_DATA;
  localparam int W_BIT  = $clog2(W_MAXB + 1);

  state_e              state;
  state_e              state_nxt;
  state_e              after_push;
  logic [W_CLKDIV-1:0] div_cnt;
  logic [W_CLKDIV-1:0] div;
  logic                clk_en;
  logic                start_q;
  logic                start_pend;
  logic [W_BIT-1:0]    bitcnt;
  logic [W_BIT-1:0]    bit_reload;
  logic [W_ADDR-1:0]   tx_sr;
  logic [W_DATA-1:0]   rx_sr;
  logic [W_DATA-1:0]   raw_word;
  logic [W_DATA-1:0]   push_word;
  logic [W_ADDR-1:0]   addr_q;
  logic [W_COUNT-1:0]  count_q;
  logic                sck_q;
  logic                mosi_q;
  logic                cs_n_q;
  logic                done_q;
  logic                shifting;
  logic                fall;
  logic                last;
  logic                pop;
  logic                can_push;
  logic                push;
  logic                fifo_full;
  logic                fifo_empty;

  assign div        = (clkdiv == '0) ? W_CLKDIV'(1) : clkdiv;
  assign clk_en     = div_cnt >= (div - W_CLKDIV'(1));
  assign start_pend = start | start_q;

  assign spi_cs_n    = cs_n_q;
  assign spi_sck     = sck_q;
  assign spi_mosi    = mosi_q;
  assign done        = done_q;
  assign addr_o      = addr_q;
  assign count_o     = count_q;
  assign rx.rx_valid = !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = pause_req ? S_PAUSED_IDLE : S_IDLE;
    end else if (clk_en) begin
      unique case (state)
        S_IDLE:
          if (start_pend)
            state_nxt = S_FRONTPORCH;
          else if (pause_req)
            state_nxt = S_PAUSED_IDLE;
        S_FRONTPORCH:
          state_nxt = S_CMD;
        S_CMD:
          if (fall && last)
            state_nxt = S_ADDR;
        S_ADDR:
          if (fall && last)
            state_nxt = (dummy_cycles == '0) ? S_DATA : S_DUMMY;
        S_DUMMY:
          if (fall && last)
            state_nxt = S_DATA;
        S_DATA:
          if (fall && last)
            state_nxt = can_push ? after_push : S_FIFO_WAIT;
        S_FIFO_WAIT:
          if (can_push)
            state_nxt = after_push;
        S_TO_PAUSE:
          state_nxt = S_PAUSED_BUSY;
        S_PAUSED_BUSY:
          if (!pause_req)
            state_nxt = S_FRONTPORCH;
        S_PAUSED_IDLE:
          if (start_pend)
            state_nxt = S_PAUSED_BUSY;
          else if (!pause_req)
            state_nxt = S_IDLE;
        S_BACKPORCH:
          state_nxt = S_IDLE;
        default:
          state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    shifting  = state inside {S_CMD, S_ADDR, S_DUMMY, S_DATA};
    fall      = clk_en & shifting & sck_q;
    last      = bitcnt == W_BIT'(1);
    busy      = !(state inside {S_IDLE, S_PAUSED_IDLE});
    pause_ack = state inside {S_PAUSED_IDLE, S_PAUSED_BUSY};
    pop       = rx.rx_valid & rx.rx_ready;
    can_push  = !fifo_full | pop;
    raw_word  = (state == S_DATA) ?
                {rx_sr[W_DATA-2:0], spi_miso} : rx_sr;
    push      = !abort & clk_en & can_push &
                ((state == S_DATA && fall && last) ||
                 state == S_FIFO_WAIT);
    if (count_q == '0)
      after_push = S_BACKPORCH;
    else if (pause_req)
      after_push = S_TO_PAUSE;
    else
      after_push = S_DATA;
    unique case (state)
      S_CMD:
        bit_reload = W_BIT'(W_ADDR);
      S_ADDR:
        bit_reload = (dummy_cycles == '0) ?
                     W_BIT'(W_DATA) : W_BIT'(dummy_cycles);
      default:
        bit_reload = W_BIT'(W_DATA);
    endcase
  end

`ifdef SPI_STREAM_ENGINE_BSWAP_EN
  always_comb begin
    push_word = raw_word;
    for (int i = 0; i < W_DATA/8; i++)
      push_word[8*i +: 8] = raw_word[W_DATA-8-8*i +: 8];
  end
`else
  assign push_word = raw_word;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      bitcnt  <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      div_cnt <= clk_en ? '0 : div_cnt + W_CLKDIV'(1);
      start_q <= clk_en ? 1'b0 : (start_q | start) & !busy;
      done_q  <= clk_en & (state == S_BACKPORCH) & !abort;
      cs_n_q  <= !(state_nxt inside {S_FRONTPORCH, S_CMD, S_ADDR,
                   S_DUMMY, S_DATA, S_FIFO_WAIT, S_BACKPORCH});
      if (abort || !shifting)
        sck_q <= 1'b0;
      else if (clk_en)
        sck_q <= ~sck_q;
      if (clk_en && state == S_FRONTPORCH) begin
        tx_sr  <= W_ADDR'(opcode) << (W_ADDR - 8);
        mosi_q <= opcode[7];
        bitcnt <= W_BIT'(8);
      end else if (fall) begin
        bitcnt <= last ? bit_reload : bitcnt - W_BIT'(1);
        tx_sr  <= (last && state == S_CMD) ? addr_q : tx_sr << 1;
        if (state == S_CMD)
          mosi_q <= last ? addr_q[W_ADDR-1] : tx_sr[W_ADDR-2];
        else if (state == S_ADDR && !last)
          mosi_q <= tx_sr[W_ADDR-2];
        else
          mosi_q <= 1'b0;
        if (state == S_DATA)
          rx_sr <= {rx_sr[W_DATA-2:0], spi_miso};
      end else if (!shifting) begin
        mosi_q <= 1'b0;
      end
      // CSR writes win over the engine's own advance
      if (addr_wen)
        addr_q <= addr_i;
      else if (push)
        addr_q <= addr_q + W_ADDR'(W_DATA/8);
      if (count_wen)
        count_q <= count_i;
      else if (push)
        count_q <= count_q - W_COUNT'(1);
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (W_DATA)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (rx.rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (rx.rx_level)
  );

endmodule
